// File: rtl/pipe_pkg.sv
// Shared pipeline constants and types for the result-steering logic.
package pipe_pkg;

    localparam int unsigned XLEN = 64;

    typedef enum logic {
        DEST_A = 1'b0,
        DEST_B = 1'b1
    } dest_e;

endpackage

// File: rtl/demux_out_fifo.sv
// DEPTH-entry synchronous FIFO with occupancy count, synchronous clear and
// asynchronous reset. Storage is zeroed on reset but not on clear.
module demux_out_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] cnt,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    // Clear dominates, so a push or pop in the clear cycle leaves no trace.
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign cnt   = cnt_q;

endmodule

// File: rtl/demux_1x2_buf.sv
// 1-to-2 result steering with a small FIFO on each output; a stalled
// consumer only blocks beats headed for its own FIFO.
module demux_1x2_buf
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sel,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_a_valid,
    input  logic                       out_a_ready,
    output logic [WIDTH-1:0]           out_a_data,
    output logic                       out_b_valid,
    input  logic                       out_b_ready,
    output logic [WIDTH-1:0]           out_b_data,
    output logic [$clog2(DEPTH+1)-1:0] cnt_a,
    output logic [$clog2(DEPTH+1)-1:0] cnt_b
);
    dest_e dest;
    logic  full_a, full_b, empty_a, empty_b;
    logic  accept;

    assign dest     = dest_e'(in_sel);
    // Only registered fullness feeds in_ready; no path from the output readies.
    assign in_ready = !flush && !((dest == DEST_B) ? full_b : full_a);
    assign accept   = in_valid && in_ready;

    assign out_a_valid = !empty_a;
    assign out_b_valid = !empty_b;

    demux_out_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (accept && (dest == DEST_A)),
        .wdata (in_data),
        .pop   (out_a_ready),
        .rdata (out_a_data),
        .cnt   (cnt_a),
        .full  (full_a),
        .empty (empty_a)
    );

    demux_out_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (accept && (dest == DEST_B)),
        .wdata (in_data),
        .pop   (out_b_ready),
        .rdata (out_b_data),
        .cnt   (cnt_b),
        .full  (full_b),
        .empty (empty_b)
    );

`ifndef SYNTHESIS
    // A refused beat may be withdrawn, but if still offered it must not change.
    hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        in_valid && !in_ready && !flush |=>
            !in_valid || ($stable(in_data) && $stable(in_sel)));
`endif

endmodule

// File: tb/tb_demux_1x2_buf.sv
// Directed bench for demux_1x2_buf: reset, per-output backpressure, flush,
// and an ordering run with random consumer stalls.
module tb_demux_1x2_buf;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             clk, rst_n, flush;
    logic             in_valid, in_ready, in_sel;
    logic [WIDTH-1:0] in_data;
    logic             out_a_valid, out_a_ready, out_b_valid, out_b_ready;
    logic [WIDTH-1:0] out_a_data, out_b_data;
    logic [CW-1:0]    cnt_a, cnt_b;

    int vectors = 0;
    int miscompares = 0;

    demux_1x2_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sel      (in_sel),
        .in_data     (in_data),
        .out_a_valid (out_a_valid),
        .out_a_ready (out_a_ready),
        .out_a_data  (out_a_data),
        .out_b_valid (out_b_valid),
        .out_b_ready (out_b_ready),
        .out_b_data  (out_b_data),
        .cnt_a       (cnt_a),
        .cnt_b       (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic sel, input logic [WIDTH-1:0] data);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        tick();
        in_valid = 1'b0;
    endtask

    logic [WIDTH-1:0] exp_a[$];
    logic [WIDTH-1:0] exp_b[$];
    logic             pend;
    int               a_sent, b_sent, a_got, b_got, cycles;
    logic             did_pop_a, did_pop_b;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out_a_ready = 1'b0; out_b_ready = 1'b0;
        #2;
        check("rst_valid_a", 64'(out_a_valid), 64'd0);
        check("rst_cnt_a", 64'(cnt_a), 64'd0);
        check("rst_data_a", out_a_data, 64'd0);
        check("rst_data_b", out_b_data, 64'd0);
        #10 rst_n = 1'b1;
        tick();

        // Reset mid-stream drops queued entries without a clock edge
        push_one(1'b0, 64'h1111);
        push_one(1'b0, 64'h2222);
        check("mid_cnt_a_before", 64'(cnt_a), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid_a", 64'(out_a_valid), 64'd0);
        check("mid_rst_cnt_a", 64'(cnt_a), 64'd0);
        rst_n = 1'b1; in_sel = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        tick();

        // Full A does not block B
        push_one(1'b0, 64'h1111);
        push_one(1'b0, 64'h2222);
        check("full_cnt_a", 64'(cnt_a), 64'd2);
        in_sel = 1'b0; #1;
        check("full_in_ready_a", 64'(in_ready), 64'd0);
        in_sel = 1'b1; in_data = 64'h3333; in_valid = 1'b1; #1;
        check("full_in_ready_b", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("b_valid", 64'(out_b_valid), 64'd1);
        check("b_data", out_b_data, 64'h3333);
        check("b_cnt", 64'(cnt_b), 64'd1);

        // Full FIFO refuses a push even while being popped
        in_valid = 1'b1; in_sel = 1'b0; in_data = 64'h4444; out_a_ready = 1'b1; #1;
        check("full_pop_in_ready", 64'(in_ready), 64'd0);
        tick();
        out_a_ready = 1'b0;
        check("full_pop_cnt_a", 64'(cnt_a), 64'd1);
        check("full_pop_head", out_a_data, 64'h2222);
        check("retry_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("retry_cnt_a", 64'(cnt_a), 64'd2);

        // Flush with cnt_a=1, cnt_b=2
        out_a_ready = 1'b1; tick(); out_a_ready = 1'b0;
        check("pre_flush_head_a", out_a_data, 64'h4444);
        push_one(1'b1, 64'h6666);
        check("pre_flush_cnt_a", 64'(cnt_a), 64'd1);
        check("pre_flush_cnt_b", 64'(cnt_b), 64'd2);
        flush = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 64'h5555; out_b_ready = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_b_ready = 1'b0;
        check("flush_cnt_a", 64'(cnt_a), 64'd0);
        check("flush_cnt_b", 64'(cnt_b), 64'd0);
        check("flush_valid_a", 64'(out_a_valid), 64'd0);
        check("flush_valid_b", 64'(out_b_valid), 64'd0);
        tick(); tick();
        check("flush_no_5555_a", 64'(out_a_valid), 64'd0);
        check("flush_no_5555_b", 64'(out_b_valid), 64'd0);

        // Concurrent push and pop keeps the count
        push_one(1'b0, 64'hAAAA);
        check("conc_cnt_before", 64'(cnt_a), 64'd1);
        check("conc_head_before", out_a_data, 64'hAAAA);
        out_a_ready = 1'b1;
        push_one(1'b0, 64'hBBBB);
        out_a_ready = 1'b0;
        check("conc_cnt_after", 64'(cnt_a), 64'd1);
        check("conc_head_after", out_a_data, 64'hBBBB);
        out_a_ready = 1'b1; tick(); out_a_ready = 1'b0;
        check("conc_drained", 64'(cnt_a), 64'd0);

        // Ordering across pointer wrap with random stalls
        pend = 1'b0; a_sent = 0; b_sent = 0; a_got = 0; b_got = 0; cycles = 0;
        while ((a_got < 10 || b_got < 6) && cycles < 500) begin
            if (!pend && (a_sent < 10 || b_sent < 6)) begin
                if (b_sent >= 6 || (a_sent < 10 && $urandom_range(1) == 0)) begin
                    in_sel = 1'b0; in_data = 64'(a_sent);
                end else begin
                    in_sel = 1'b1; in_data = {32'hB0B0_0000, $urandom};
                end
                pend = 1'b1;
            end
            in_valid    = pend;
            out_a_ready = ($urandom_range(2) != 0);
            out_b_ready = ($urandom_range(2) != 0);
            #1;
            did_pop_a = out_a_valid && out_a_ready;
            did_pop_b = out_b_valid && out_b_ready;
            if (did_pop_a) begin
                check("order_a", out_a_data, (exp_a.size() != 0) ? exp_a.pop_front() : 64'hDEAD);
                a_got++;
            end
            if (did_pop_b) begin
                check("order_b", out_b_data, (exp_b.size() != 0) ? exp_b.pop_front() : 64'hDEAD);
                b_got++;
            end
            if (in_valid && in_ready) begin
                if (in_sel) begin exp_b.push_back(in_data); b_sent++; end
                else begin exp_a.push_back(in_data); a_sent++; end
                pend = 1'b0;
            end
            tick();
            in_valid = 1'b0;
            cycles++;
        end
        out_a_ready = 1'b0; out_b_ready = 1'b0;
        check("order_a_count", 64'(a_got), 64'd10);
        check("order_b_count", 64'(b_got), 64'd6);
        check("order_a_empty", 64'(cnt_a), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux_1x2_buf.md
Name: demux_1x2_buf

Overview:
- 1-to-2 steering block with buffered outputs, the distribution counterpart of the pipeline's 2:1 select muxes.
- Routes a WIDTH-bit result stream from one producer, such as the EX stage, to one of two consumers, such as the ALU writeback path or a multi-cycle unit, using a per-beat select.
- Each output has a small FIFO, so a stalled consumer does not block beats bound for the other consumer until its own FIFO fills.
- Sits between pipeline stages and uses valid/ready handshakes on every side.

Parameters:
- WIDTH, 64, data width in bits.
- DEPTH, 2, entries per output FIFO. Must be a power of 2 and at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of both FIFOs (branch mispredict or trap).
- in_valid  input  1  producer has a beat.
- in_ready  output  1  beat is accepted this cycle.
- in_sel  input  1  destination: 0 = output A, 1 = output B.
- in_data  input  WIDTH  payload.
- out_a_valid  output  1  FIFO A non-empty.
- out_a_ready  input  1  consumer A takes the head entry.
- out_a_data  output  WIDTH  head of FIFO A.
- out_b_valid  output  1  FIFO B non-empty.
- out_b_ready  input  1  consumer B takes the head entry.
- out_b_data  output  WIDTH  head of FIFO B.
- cnt_a  output  $clog2(DEPTH+1)  occupancy of FIFO A.
- cnt_b  output  $clog2(DEPTH+1)  occupancy of FIFO B.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Read/write pointers and counts clear to 0 immediately.
  - out_a_valid, out_b_valid = 0.
  - cnt_a, cnt_b = 0.
  - Storage is cleared to 0, so out_a_data and out_b_data read 0.
  - Reset is honoured mid-transfer; in-flight entries are lost.
- in_ready = !flush && !full[in_sel].
  - Combinational from in_sel, flush and registered counts only.
  - No combinational path from out_*_ready to in_ready: a full FIFO refuses a push even in a cycle where it is popped.
- Push: when in_valid && in_ready, in_data is written to FIFO[in_sel] at its write pointer, the pointer increments, and count increments.
- Pop on output k: when out_k_valid && out_k_ready, the read pointer increments and count decrements.
- Simultaneous push and pop on the same FIFO (non-full, non-empty): count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Latency: a beat pushed at edge N is visible on out_k_data / out_k_valid after edge N. Minimum 1 cycle; there is no bypass path.
- Throughput: one beat per cycle per direction while the target FIFO is not full.
- out_k_valid = (cnt_k != 0).
- out_k_data = storage[rd_ptr_k]. It is checked only while out_k_valid is high.
- Ordering:
  - FIFO order is preserved within each output.
  - No ordering relation between the A and B streams.
- in_valid while !in_ready: the beat is not taken. The producer holds in_data and in_sel stable until acceptance; holding them stable is the producer's responsibility and is checked by assertion.
- flush (registered effect):
  - At the next edge, both FIFOs empty (pointers and counts reset to 0).
  - Pops in the flush cycle have no further effect.
  - in_ready = 0 during flush, so no beat is accepted.
  - Storage contents are not cleared by flush.
- Reset has priority over flush. flush has priority over push and pop.
- Empty FIFO with out_k_ready high: no state change.
- Full FIFO: cnt_k = DEPTH. The other FIFO continues to accept beats.

Decomposition:
- Package pipe_pkg:
  - XLEN = 64 constant, used as the WIDTH default.
  - typedef dest_e {DEST_A = 1'b0, DEST_B = 1'b1} for in_sel.
- One natural sub-module, demux_out_fifo (DEPTH-entry synchronous FIFO), instantiated twice.
  - Ports: clk, rst_n, clr, push, wdata, pop, rdata, cnt, full, empty.
  - The top level holds only the steering logic and the in_ready equation.

Test Plan:
- Reset mid-stream: FIFO A holding 0x1111 and 0x2222, drop rst_n between edges → out_a_valid=0 and cnt_a=0 immediately, with no clock edge. After release with in_sel=0, in_ready=1.
- Independent full: out_a_ready=0, push 0x1111 then 0x2222 with in_sel=0 → cnt_a=2 and in_ready=0 for in_sel=0. Switch to in_sel=1, push 0x3333 → accepted, out_b_data=0x3333 one cycle later.
- Concurrent push/pop: cnt_a=1 (head 0xAAAA); push 0xBBBB while out_a_ready=1 → cnt_a stays 1, out_a_data=0xBBBB next cycle.
- Full refuses push on pop cycle: cnt_a=2, in_valid=1 with 0x4444, out_a_ready pulsed for one cycle → no accept that cycle. Beat accepted the following cycle, cnt_a returns to 2.
- Flush: cnt_a=1, cnt_b=2, flush=1 with in_valid=1 and 0x5555 → in_ready=0 that cycle. Next cycle cnt_a=cnt_b=0, and 0x5555 never appears on either output.
- Wrap/ordering: push 0x0..0x9 to A under random out_a_ready, interleaved with random beats to B → A emits 0x0..0x9 in order, and B emits its own sequence intact.
